// File: rtl/ps2_receive.sv
// PS/2 device-to-host frame receiver: filters PS2C/PS2D, captures 11-bit frames
// and reports each good byte with a one-cycle strobe or a coded error pulse.
module ps2_receive #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000,
    parameter int TO_W       = 16
) (
    input  logic       qzt_clk,
    input  logic       rst_n,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       enable,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [3:0] status
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        c_sync_q, d_sync_q;
    logic              c_filt_q, c_filt_d;
    logic              d_filt_q, d_filt_d;
    logic [FC_W-1:0]   c_cnt_q, c_cnt_d;
    logic [FC_W-1:0]   d_cnt_q, d_cnt_d;
    logic              c_prev_q;
    logic              fall;
    logic [10:0]       frame_q, frame_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              err_sticky_q, err_sticky_d;
    logic              valid_sticky_q, valid_sticky_d;

    // A filtered line only follows the synchronized input after FILTER_LEN
    // consecutive samples disagree with it.
    always_comb begin
        c_cnt_d  = '0;
        c_filt_d = c_filt_q;
        if (c_sync_q[1] != c_filt_q) begin
            if (c_cnt_q == FC_W'(FILTER_LEN - 1)) begin
                c_filt_d = c_sync_q[1];
            end else begin
                c_cnt_d = c_cnt_q + 1'b1;
            end
        end
        d_cnt_d  = '0;
        d_filt_d = d_filt_q;
        if (d_sync_q[1] != d_filt_q) begin
            if (d_cnt_q == FC_W'(FILTER_LEN - 1)) begin
                d_filt_d = d_sync_q[1];
            end else begin
                d_cnt_d = d_cnt_q + 1'b1;
            end
        end
    end

    assign fall = c_prev_q & ~c_filt_q;

    always_comb begin
        state_d        = state_q;
        frame_d        = frame_q;
        bit_cnt_d      = bit_cnt_q;
        to_cnt_d       = to_cnt_q;
        data_d         = data_q;
        valid_d        = 1'b0;
        err_d          = 1'b0;
        err_code_d     = err_code_q;
        err_sticky_d   = err_sticky_q;
        valid_sticky_d = valid_sticky_q;
        case (state_q)
            IDLE: begin
                if (fall && enable) begin
                    frame_d   = {d_filt_q, frame_q[10:1]};
                    bit_cnt_d = 4'd1;
                    to_cnt_d  = '0;
                    state_d   = RECV;
                end
            end
            RECV: begin
                // Enable drop beats a fall, and a fall beats a timeout.
                if (!enable) begin
                    bit_cnt_d = 4'd0;
                    state_d   = IDLE;
                end else if (fall) begin
                    frame_d   = {d_filt_q, frame_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    to_cnt_d  = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d        = 1'b1;
                    err_code_d   = 2'd3;
                    err_sticky_d = 1'b1;
                    bit_cnt_d    = 4'd0;
                    state_d      = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                bit_cnt_d = 4'd0;
                state_d   = IDLE;
                if (frame_q[0] != 1'b0) begin
                    err_d        = 1'b1;
                    err_code_d   = 2'd1;
                    err_sticky_d = 1'b1;
                end else if (^frame_q[9:1] != 1'b1) begin
                    err_d        = 1'b1;
                    err_code_d   = 2'd2;
                    err_sticky_d = 1'b1;
                end else if (frame_q[10] != 1'b1) begin
                    err_d        = 1'b1;
                    err_code_d   = 2'd3;
                    err_sticky_d = 1'b1;
                end else begin
                    data_d         = frame_q[8:1];
                    valid_d        = 1'b1;
                    valid_sticky_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            c_sync_q       <= 2'b11;
            d_sync_q       <= 2'b11;
            c_filt_q       <= 1'b1;
            d_filt_q       <= 1'b1;
            c_cnt_q        <= '0;
            d_cnt_q        <= '0;
            c_prev_q       <= 1'b1;
            frame_q        <= '0;
            bit_cnt_q      <= '0;
            to_cnt_q       <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
            err_sticky_q   <= 1'b0;
            valid_sticky_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            c_sync_q       <= {c_sync_q[0], PS2C};
            d_sync_q       <= {d_sync_q[0], PS2D};
            c_filt_q       <= c_filt_d;
            d_filt_q       <= d_filt_d;
            c_cnt_q        <= c_cnt_d;
            d_cnt_q        <= d_cnt_d;
            c_prev_q       <= c_filt_q;
            frame_q        <= frame_d;
            bit_cnt_q      <= bit_cnt_d;
            to_cnt_q       <= to_cnt_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            err_sticky_q   <= err_sticky_d;
            valid_sticky_q <= valid_sticky_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q == RECV);
    assign status   = {busy, err_sticky_q, bit_cnt_q == 4'd10, valid_sticky_q};

endmodule

// File: tb/tb_ps2_receive.sv
// Self-checking bench for ps2_receive: directed frames from the test plan plus
// random frames, compared against a frame-level reference model.
module tb_ps2_receive;

    logic       qzt_clk;
    logic       rst_n;
    logic       PS2C;
    logic       PS2D;
    logic       enable;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;
    logic [3:0] status;

    localparam int HALF = 40;

    int vectors;
    int miscompares;
    int cycle_cnt;
    int valid_pulses;
    int err_pulses;
    int valid_run;
    int max_valid_run;
    int err_cycle;
    int last_fall_cycle;

    logic [7:0] exp_data;
    logic [1:0] exp_code;
    logic       exp_err_sticky;
    logic       exp_valid_sticky;

    ps2_receive dut (
        .qzt_clk  (qzt_clk),
        .rst_n    (rst_n),
        .PS2C     (PS2C),
        .PS2D     (PS2D),
        .enable   (enable),
        .data     (data),
        .valid    (valid),
        .err      (err),
        .err_code (err_code),
        .busy     (busy),
        .status   (status)
    );

    initial qzt_clk = 1'b0;
    always #10 qzt_clk = ~qzt_clk;

    always @(posedge qzt_clk) cycle_cnt <= cycle_cnt + 1;

    // Pulse monitor sampled away from the active edge.
    always @(negedge qzt_clk) begin
        if (valid) begin
            valid_pulses = valid_pulses + 1;
            valid_run    = valid_run + 1;
            if (valid_run > max_valid_run) max_valid_run = valid_run;
        end else begin
            valid_run = 0;
        end
        if (err) begin
            err_pulses = err_pulses + 1;
            err_cycle  = cycle_cnt;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        if (observed !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge qzt_clk);
        #1;
    endtask

    function automatic logic [10:0] buildFrame(input logic [7:0] b, input int kind);
        logic start_bit;
        logic parity_bit;
        logic stop_bit;
        start_bit  = (kind == 1);
        parity_bit = ~(^b) ^ (kind == 2);
        stop_bit   = (kind != 3);
        return {stop_bit, parity_bit, b, start_bit};
    endfunction

    // Reference rule: 0 = good frame, otherwise the error code it must raise.
    function automatic int modelCode(input logic [10:0] f);
        int ones;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones = ones + int'(f[i]);
        if (f[0] != 1'b0) return 1;
        if (ones % 2 != 1) return 2;
        if (f[10] != 1'b1) return 3;
        return 0;
    endfunction

    // Drives nbits of a frame, bit 0 first; cg/dg pick a bit to glitch (-1 = none).
    task automatic applyStimulus(input logic [10:0] f, input int nbits, input int cg, input int dg);
        for (int i = 0; i < nbits; i++) begin
            PS2D = f[i];
            if (i == cg) begin
                waitCycles(10);
                PS2C = 1'b0;
                waitCycles(3);
                PS2C = 1'b1;
                waitCycles(HALF - 13);
            end else if (i == dg) begin
                waitCycles(HALF - 2);
                PS2D = ~f[i];
                waitCycles(2);
            end else begin
                waitCycles(HALF);
            end
            PS2C            = 1'b0;
            last_fall_cycle = cycle_cnt;
            if (i == dg) begin
                waitCycles(1);
                PS2D = f[i];
                waitCycles(HALF - 1);
            end else begin
                waitCycles(HALF);
            end
            PS2C = 1'b1;
        end
        PS2D = 1'b1;
    endtask

    task automatic clearMonitor();
        valid_pulses  = 0;
        err_pulses    = 0;
        max_valid_run = 0;
        err_cycle     = 0;
    endtask

    task automatic checkFrame(input string tag, input logic [10:0] f, input int cg, input int dg);
        int code;
        clearMonitor();
        applyStimulus(f, 11, cg, dg);
        waitCycles(60);
        code = modelCode(f);
        if (code == 0) begin
            exp_data         = f[8:1];
            exp_valid_sticky = 1'b1;
        end else begin
            exp_code       = 2'(code);
            exp_err_sticky = 1'b1;
        end
        checkOutput({tag, "_valid_cnt"}, valid_pulses, (code == 0) ? 1 : 0);
        checkOutput({tag, "_err_cnt"}, err_pulses, (code == 0) ? 0 : 1);
        if (code == 0) checkOutput({tag, "_valid_width"}, max_valid_run, 1);
        checkOutput({tag, "_data"}, data, exp_data);
        checkOutput({tag, "_err_code"}, err_code, exp_code);
        checkOutput({tag, "_status"}, status, {1'b0, exp_err_sticky, 1'b0, exp_valid_sticky});
    endtask

    initial begin
        logic [10:0] f;
        int          lat;
        vectors          = 0;
        miscompares      = 0;
        cycle_cnt        = 0;
        valid_run        = 0;
        last_fall_cycle  = 0;
        exp_data         = 8'h00;
        exp_code         = 2'd0;
        exp_err_sticky   = 1'b0;
        exp_valid_sticky = 1'b0;
        clearMonitor();
        rst_n  = 1'b0;
        PS2C   = 1'b1;
        PS2D   = 1'b1;
        enable = 1'b1;
        waitCycles(5);
        checkOutput("rst_data", data, 8'h00);
        checkOutput("rst_valid", valid, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_err_code", err_code, 2'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_status", status, 4'h0);
        rst_n = 1'b1;
        waitCycles(20);

        checkFrame("fa", buildFrame(8'hFA, 0), -1, -1);
        checkFrame("aa_par", buildFrame(8'hAA, 2), -1, -1);
        checkFrame("00_stop", buildFrame(8'h00, 3), -1, -1);
        checkFrame("00_good", buildFrame(8'h00, 0), -1, -1);

        // Five falls then a silent bus must time out.
        clearMonitor();
        applyStimulus(buildFrame(8'h33, 0), 5, -1, -1);
        waitCycles(10500);
        lat = err_cycle - last_fall_cycle;
        exp_code       = 2'd3;
        exp_err_sticky = 1'b1;
        checkOutput("to_err_cnt", err_pulses, 1);
        checkOutput("to_valid_cnt", valid_pulses, 0);
        checkOutput("to_latency_ok", (lat >= 10000 && lat <= 10040) ? 1 : 0, 1);
        checkOutput("to_err_code", err_code, 2'd3);
        checkOutput("to_busy", busy, 1'b0);
        checkFrame("55", buildFrame(8'h55, 0), -1, -1);

        checkFrame("3c_cglitch", buildFrame(8'h3C, 0), 4, -1);
        checkFrame("3c_dglitch", buildFrame(8'h3C, 0), -1, 5);

        // Reset mid-frame aborts silently and clears everything.
        clearMonitor();
        applyStimulus(buildFrame(8'h12, 0), 4, -1, -1);
        checkOutput("rstmid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(60);
        exp_data         = 8'h00;
        exp_code         = 2'd0;
        exp_err_sticky   = 1'b0;
        exp_valid_sticky = 1'b0;
        checkOutput("rstmid_pulses", valid_pulses + err_pulses, 0);
        checkOutput("rstmid_busy", busy, 1'b0);
        checkOutput("rstmid_status", status, 4'h0);

        // Enable drop mid-frame discards it without an error.
        clearMonitor();
        f = buildFrame(8'h12, 0);
        applyStimulus(f, 6, -1, -1);
        waitCycles(20);
        enable = 1'b0;
        waitCycles(5);
        checkOutput("en_busy", busy, 1'b0);
        applyStimulus(f >> 6, 5, -1, -1);
        waitCycles(20);
        enable = 1'b1;
        waitCycles(20);
        checkOutput("en_pulses", valid_pulses + err_pulses, 0);
        checkOutput("en_data", data, exp_data);
        checkFrame("12_after_en", f, -1, -1);

        for (int n = 0; n < 12; n++) begin
            int kind;
            kind = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            checkFrame($sformatf("rnd%0d", n), buildFrame(8'($urandom_range(0, 255)), kind), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_receive.md
Name: ps2_receive

Overview:
- Device-to-host PS/2 frame receiver: the inbound counterpart of PS2_send, used to read mouse replies (ACK 0xFA, movement packets) on PS2_CLK1/PS2_DATA1.
- Samples the open-collector lines with filtering and captures 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Presents each byte with a one-cycle valid strobe and reports error conditions.
- Never drives the bus. `enable` lets the top level mute it while PS2_send owns the lines.

Parameters:
- FILTER_LEN, 8: consecutive identical qzt_clk samples needed before filtered PS2C/PS2D change (160 ns at 50 MHz).
- TIMEOUT, 10000: qzt_clk cycles allowed between PS2C falling edges inside a frame (200 us).
- TO_W, 16: width of the timeout counter. Must hold TIMEOUT.

Ports:
- qzt_clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- PS2C  input  1  PS/2 clock line, read only.
- PS2D  input  1  PS/2 data line, read only.
- enable  input  1  1 = receive; 0 = hold in IDLE and discard partial frame.
- data  output  8  last good byte; holds until the next good frame.
- valid  output  1  one-cycle pulse when `data` is updated.
- err  output  1  one-cycle pulse on a rejected frame.
- err_code  output  2  cause of last error: 1 start, 2 parity, 3 stop/timeout. Held until next error.
- busy  output  1  high while in RECV.
- status  output  4  debug, for LEDs: {busy, err_sticky, bit_cnt==10, valid_sticky}. Sticky bits clear on reset only.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, data=0, valid=0, err=0, err_code=0, busy=0, status=0. Synchronizers and filters preset to 1 (idle bus).
- Input path: 2-FF synchronizer per line, then a filter. A filtered line changes only after FILTER_LEN equal samples.
- A falling edge (fall) is a cycle where filtered PS2C goes from 1 to 0. Filtered PS2D is sampled in the same cycle.
- IDLE:
  - fall with enable=1 -> store bit0 (start), bit_cnt=1, clear timeout counter, go to RECV.
  - fall with enable=0 is ignored.
- RECV:
  - Each fall shifts in filtered PS2D LSB-first and increments bit_cnt. The timeout counter resets on each fall and otherwise increments.
  - After the fall that makes bit_cnt=11 -> CHECK.
  - Timeout counter reaching TIMEOUT -> err pulse, err_code=3, go to IDLE.
  - enable falling to 0 -> IDLE, no err, frame discarded.
- CHECK (one cycle), checks in priority order:
  - start!=0 -> err_code=1.
  - else XOR(data bits, parity) != 1 -> err_code=2.
  - else stop!=1 -> err_code=3.
  - else data<=byte and valid=1.
  - Always return to IDLE. Output latency: valid is asserted 2 qzt_clk cycles after the 11th filtered fall.
- Same-cycle events: a fall and a timeout in the same cycle -> the fall wins (bit is taken). An enable drop and a fall in the same cycle -> the enable drop wins.
- A back-to-back frame's start bit can be accepted the cycle after CHECK.
- rst_n asserted mid-frame -> immediate IDLE; no valid/err is produced for the aborted frame.

Test Plan:
- Frame 0xFA (bits 0,0,1,0,1,1,1,1,1,1,1 in line order, PS2C period 80 us) -> data=0xFA, valid high exactly 1 cycle, err=0, status[0]=1.
- Frame 0xAA with parity bit 0 -> err pulse, err_code=2, data unchanged (still 0xFA), valid=0.
- Frame 0x00 with stop bit 0 -> err_code=3. Next frame 0x00 with parity 1, stop 1 -> data=0x00, valid.
- 5 falling edges, then PS2C held high 300 us -> err pulse 10000 cycles after the 5th fall, err_code=3, busy=0. A following full 0x55 frame -> data=0x55.
- 3-cycle low glitch on PS2C mid-frame -> ignored; byte 0x3C still received correctly. Same glitch on PS2D at the sample point, shorter than FILTER_LEN -> original bit is kept.
- Both interrupts during frame 0x12: rst_n low after bit 4 -> no valid/err, busy=0. Separately, enable=0 after bit 6 -> no err, busy=0, next frame 0x12 received.
